// File: rtl/sar_adc_controller.sv
// rtl/sar_adc_controller.sv - successive-approximation ADC sequencer driving R2R DAC trial codes
module sar_adc_controller #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             cont,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] DECIDE = 2'd2;

    localparam logic [WIDTH-1:0] MSB_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0]    BIT_TOP   = BW'(WIDTH - 1);

    logic [1:0]       state;
    logic [BW-1:0]    bit_idx;
    logic [CW-1:0]    cnt;
    logic             cmp_meta;
    logic             cmp_s;
    logic [WIDTH-1:0] decided;

    // Current trial with the bit under test resolved and the next lower bit raised.
    always_comb begin
        decided          = dac_out;
        decided[bit_idx] = cmp_s;
        if (bit_idx != '0) begin
            decided[bit_idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            dac_out  <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
            cnt      <= '0;
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dac_out <= MSB_TRIAL;
                        bit_idx <= BIT_TOP;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    if (bit_idx != '0) begin
                        dac_out <= decided;
                        bit_idx <= bit_idx - 1'b1;
                        cnt     <= '0;
                        state   <= SETTLE;
                    end else begin
                        result <= decided;
                        done   <= 1'b1;
                        // Continuous mode chains straight into the next MSB trial.
                        if (cont) begin
                            dac_out <= MSB_TRIAL;
                            bit_idx <= BIT_TOP;
                            cnt     <= '0;
                            state   <= SETTLE;
                        end else begin
                            dac_out <= decided;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
